// File: rtl/toaplan2_snd_mixer.sv
// N-channel sound mixer: snapshot on CEN, serial 4.4 gain MAC (one channel per clock),
// output saturation and a click-free soft-mute ramp.
module toaplan2_snd_mixer #(
   parameter int unsigned NCH  = 4,
   parameter int unsigned W    = 16,
   parameter int unsigned WOUT = 16
) (
   input  logic                 CLK96,
   input  logic                 RESET96_N,
   input  logic                 CEN,
   input  logic [NCH*W-1:0]     CH_IN,
   input  logic [NCH*8-1:0]     GAIN,
   input  logic                 MUTE,
   input  logic                 PEAK_CLR,
   output logic [WOUT-1:0]      MIXED,
   output logic                 SAMPLE,
   output logic                 BUSY,
   output logic                 PEAK,
   output logic                 OVERRUN
);

   localparam int unsigned ACCW = W + 9 + $clog2(NCH) + 1;
   localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned PW   = W + 9;
   localparam int unsigned MW   = WOUT + 6;

   localparam logic signed [ACCW-1:0] SMAX = {{(ACCW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_SCALE = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         idx_q, idx_d;
   logic signed [ACCW-1:0]  acc_q, acc_d;
   logic signed [W-1:0]     ch_snap_q [NCH];
   logic signed [W-1:0]     ch_snap_d [NCH];
   logic [7:0]              gain_snap_q [NCH];
   logic [7:0]              gain_snap_d [NCH];
   logic signed [WOUT-1:0]  m_q, m_d;
   logic [WOUT-1:0]         mixed_q, mixed_d;
   logic                    sample_q, sample_d;
   logic                    busy_q, busy_d;
   logic                    peak_q, peak_d;
   logic                    overrun_q, overrun_d;
   logic [4:0]              att_q, att_d;

   logic signed [PW-1:0]    prod_c;
   logic signed [ACCW-1:0]  s_c;
   logic signed [WOUT-1:0]  s_sat_c;
   logic                    clip_c;
   logic [4:0]              att_gain_c;
   logic signed [MW-1:0]    m_full_c;
   logic signed [WOUT-1:0]  m_c;

   // Datapath: current-channel product and the scale/saturate/ramp stage.
   always_comb begin
      prod_c     = ch_snap_q[idx_q] * $signed({1'b0, gain_snap_q[idx_q]});
      s_c        = acc_q >>> 4;
      clip_c     = 1'b0;
      s_sat_c    = WOUT'(s_c);
      if (s_c > SMAX) begin
         s_sat_c = WOUT'(SMAX);
         clip_c  = 1'b1;
      end else if (s_c < SMIN) begin
         s_sat_c = WOUT'(SMIN);
         clip_c  = 1'b1;
      end
      att_gain_c = 5'(5'd16 - att_q);
      m_full_c   = s_sat_c * $signed({1'b0, att_gain_c});
      m_c        = WOUT'(m_full_c >>> 4);
   end

   // Sequencer: BUSY stays high through the SAMPLE cycle, so the IDLE accept test uses busy_q.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      ch_snap_d   = ch_snap_q;
      gain_snap_d = gain_snap_q;
      m_d         = m_q;
      mixed_d     = mixed_q;
      sample_d    = 1'b0;
      busy_d      = busy_q;
      peak_d      = peak_q;
      overrun_d   = overrun_q;
      att_d       = att_q;

      if (PEAK_CLR) begin
         peak_d    = 1'b0;
         overrun_d = 1'b0;
      end
      if (sample_q) begin
         busy_d = 1'b0;
      end
      if (CEN && busy_q) begin
         overrun_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (CEN && !busy_q) begin
               for (int i = 0; i < NCH; i++) begin
                  ch_snap_d[i]   = CH_IN[i*W +: W];
                  gain_snap_d[i] = GAIN[i*8 +: 8];
               end
               acc_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b1;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            acc_d = acc_q + ACCW'(prod_c);
            idx_d = idx_q + 1'b1;
            if (idx_q == IDXW'(NCH - 1)) begin
               state_d = ST_SCALE;
            end
         end
         ST_SCALE: begin
            m_d = m_c;
            if (clip_c) begin
               peak_d = 1'b1;
            end
            state_d = ST_OUT;
         end
         ST_OUT: begin
            mixed_d  = m_q;
            sample_d = 1'b1;
            if (MUTE && (att_q < 5'd16)) begin
               att_d = att_q + 5'd1;
            end else if (!MUTE && (att_q != 5'd0)) begin
               att_d = att_q - 5'd1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK96 or negedge RESET96_N) begin
      if (!RESET96_N) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         acc_q     <= '0;
         for (int i = 0; i < NCH; i++) begin
            ch_snap_q[i]   <= '0;
            gain_snap_q[i] <= '0;
         end
         m_q       <= '0;
         mixed_q   <= '0;
         sample_q  <= 1'b0;
         busy_q    <= 1'b0;
         peak_q    <= 1'b0;
         overrun_q <= 1'b0;
         att_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         ch_snap_q   <= ch_snap_d;
         gain_snap_q <= gain_snap_d;
         m_q         <= m_d;
         mixed_q     <= mixed_d;
         sample_q    <= sample_d;
         busy_q      <= busy_d;
         peak_q      <= peak_d;
         overrun_q   <= overrun_d;
         att_q       <= att_d;
      end
   end

   assign MIXED   = mixed_q;
   assign SAMPLE  = sample_q;
   assign BUSY    = busy_q;
   assign PEAK    = peak_q;
   assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_toaplan2_snd_mixer.sv
// Bench for toaplan2_snd_mixer: directed cases plus random mixes against an arithmetic model.
module tb_toaplan2_snd_mixer;

   localparam int unsigned NCH  = 4;
   localparam int unsigned W    = 16;
   localparam int unsigned WOUT = 16;

   logic                CLK96 = 1'b0;
   logic                RESET96_N;
   logic                CEN;
   logic [NCH*W-1:0]    CH_IN;
   logic [NCH*8-1:0]    GAIN;
   logic                MUTE;
   logic                PEAK_CLR;
   logic [WOUT-1:0]     MIXED;
   logic                SAMPLE;
   logic                BUSY;
   logic                PEAK;
   logic                OVERRUN;

   int n_tests = 0;
   int n_fail  = 0;
   int m_att   = 0;
   bit m_peak  = 1'b0;
   bit m_ovr   = 1'b0;

   toaplan2_snd_mixer #(.NCH(NCH), .W(W), .WOUT(WOUT)) dut (
      .CLK96(CLK96), .RESET96_N(RESET96_N), .CEN(CEN), .CH_IN(CH_IN), .GAIN(GAIN),
      .MUTE(MUTE), .PEAK_CLR(PEAK_CLR), .MIXED(MIXED), .SAMPLE(SAMPLE), .BUSY(BUSY),
      .PEAK(PEAK), .OVERRUN(OVERRUN)
   );

   always #5 CLK96 = ~CLK96;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pk4(input logic [15:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference: signed sum of ch*gain, /16 floored, clamp, attenuate by (16-att)/16 floored.
   task automatic model_step(input logic [NCH*W-1:0] ch, input logic [NCH*8-1:0] g,
                             output logic [WOUT-1:0] e);
      longint sum, s, m, smax, smin;
      sum  = 0;
      smax = (longint'(1) <<< (WOUT - 1)) - 1;
      smin = -(longint'(1) <<< (WOUT - 1));
      for (int i = 0; i < NCH; i++) begin
         logic [W-1:0] c;
         logic [7:0]   gg;
         c   = ch[i*W +: W];
         gg  = g[i*8 +: 8];
         sum = sum + longint'($signed(c)) * longint'(gg);
      end
      s = sum >>> 4;
      if (s > smax) begin
         s = smax;
         m_peak = 1'b1;
      end else if (s < smin) begin
         s = smin;
         m_peak = 1'b1;
      end
      m = (s * longint'(16 - m_att)) >>> 4;
      e = WOUT'(m);
      if (MUTE && m_att < 16) m_att++;
      else if (!MUTE && m_att > 0) m_att--;
   endtask

   // Issue one CEN, scramble inputs while busy, optionally inject a second CEN, check the result.
   task automatic run_mix(input logic [NCH*W-1:0] ch, input logic [NCH*8-1:0] g,
                          input int inj, input bit inj_clr, input string tag);
      logic [WOUT-1:0] e;
      int lat;
      CH_IN = ch;
      GAIN  = g;
      CEN   = 1'b1;
      @(negedge CLK96);
      CEN   = 1'b0;
      CH_IN = rnd64();
      GAIN  = $urandom;
      lat   = 0;
      while (SAMPLE !== 1'b1 && lat < 20) begin
         @(negedge CLK96);
         lat++;
         CEN      = 1'b0;
         PEAK_CLR = 1'b0;
         if (lat == inj) begin
            CEN      = 1'b1;
            PEAK_CLR = inj_clr;
            if (inj_clr) m_peak = 1'b0;
            m_ovr = 1'b1;
         end
         CH_IN = rnd64();
         GAIN  = $urandom;
      end
      CEN      = 1'b0;
      PEAK_CLR = 1'b0;
      model_step(ch, g, e);
      check({tag, "_lat"}, 32'(lat), 32'(NCH + 2));
      check({tag, "_mixed"}, 32'(MIXED), 32'(e));
      check({tag, "_peak"}, 32'(PEAK), 32'(m_peak));
      check({tag, "_ovr"}, 32'(OVERRUN), 32'(m_ovr));
      check({tag, "_busy"}, 32'(BUSY), 32'd1);
   endtask

   task automatic finish_idle(input string tag);
      @(negedge CLK96);
      check({tag, "_busy_lo"}, 32'(BUSY), 32'd0);
      check({tag, "_samp_lo"}, 32'(SAMPLE), 32'd0);
   endtask

   task automatic clear_flags();
      PEAK_CLR = 1'b1;
      @(negedge CLK96);
      PEAK_CLR = 1'b0;
      m_peak = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic count_samples(input int cycles, input string tag);
      int ns;
      ns = 0;
      repeat (cycles) begin
         @(negedge CLK96);
         if (SAMPLE === 1'b1) ns++;
      end
      check(tag, 32'(ns), 32'd0);
   endtask

   initial begin
      RESET96_N = 1'b0;
      CEN       = 1'b0;
      CH_IN     = '0;
      GAIN      = '0;
      MUTE      = 1'b0;
      PEAK_CLR  = 1'b0;
      repeat (3) @(negedge CLK96);
      check("rst_mixed", 32'(MIXED), 32'd0);
      check("rst_sample", 32'(SAMPLE), 32'd0);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_peak", 32'(PEAK), 32'd0);
      check("rst_ovr", 32'(OVERRUN), 32'd0);
      RESET96_N = 1'b1;
      @(negedge CLK96);

      // Unity gain on a single channel
      run_mix(pk4(16'h1000, 16'h1234, 16'h4321, 16'h7777), 32'h0000_0010, -1, 1'b0, "t1");
      check("t1_lit", 32'(MIXED), 32'h1000);
      finish_idle("t1");

      // Fractional gains and negative input
      run_mix(pk4(16'h0100, 0, 0, 0), 32'h0000_0008, -1, 1'b0, "t2a");
      check("t2a_lit", 32'(MIXED), 32'h0080);
      finish_idle("t2a");
      run_mix(pk4(16'h0100, 0, 0, 0), 32'h0000_0018, -1, 1'b0, "t2b");
      check("t2b_lit", 32'(MIXED), 32'h0180);
      finish_idle("t2b");
      run_mix(pk4(16'hFF00, 0, 0, 0), 32'h0000_0008, -1, 1'b0, "t2c");
      check("t2c_lit", 32'(MIXED), 32'hFF80);
      finish_idle("t2c");

      // Saturation both ways, then clear
      run_mix(pk4(16'h7000, 16'h7000, 0, 0), 32'h0000_1010, -1, 1'b0, "t3a");
      check("t3a_lit", 32'(MIXED), 32'h7FFF);
      check("t3a_peak_lit", 32'(PEAK), 32'd1);
      finish_idle("t3a");
      run_mix(pk4(16'h9000, 16'h9000, 0, 0), 32'h0000_1010, -1, 1'b0, "t3b");
      check("t3b_lit", 32'(MIXED), 32'h8000);
      finish_idle("t3b");
      clear_flags();
      check("t3_peak_clr", 32'(PEAK), 32'd0);

      // Mute ramp down, then back up
      MUTE = 1'b1;
      for (int k = 0; k < 18; k++) begin
         run_mix(pk4(16'h1000, 0, 0, 0), 32'h0000_0010, -1, 1'b0, "t4d");
         check("t4d_lit", 32'(MIXED), (k < 16) ? 32'(16'h1000 - 16'(k) * 16'h0100) : 32'd0);
         finish_idle("t4d");
      end
      MUTE = 1'b0;
      for (int k = 0; k < 17; k++) begin
         run_mix(pk4(16'h1000, 0, 0, 0), 32'h0000_0010, -1, 1'b0, "t4u");
         check("t4u_lit", 32'(MIXED), 32'(16'(k) * 16'h0100));
         finish_idle("t4u");
      end

      // Overrun: second CEN 3 cycles after the first, with PEAK_CLR on the same cycle
      clear_flags();
      check("t5_ovr0", 32'(OVERRUN), 32'd0);
      run_mix(pk4(16'h0200, 16'h0300, 16'hFC00, 16'h0040), 32'h2010_0818, 2, 1'b1, "t5");
      check("t5_ovr_lit", 32'(OVERRUN), 32'd1);
      finish_idle("t5");
      count_samples(12, "t5_extra_samples");

      // CEN on the SAMPLE cycle is dropped; CEN on the next cycle is taken
      clear_flags();
      run_mix(pk4(16'h0400, 0, 0, 0), 32'h0000_0010, -1, 1'b0, "t5b");
      CEN = 1'b1;
      @(negedge CLK96);
      CEN = 1'b0;
      m_ovr = 1'b1;
      check("t5b_drop_samp", 32'(SAMPLE), 32'd0);
      check("t5b_drop_busy", 32'(BUSY), 32'd0);
      check("t5b_drop_ovr", 32'(OVERRUN), 32'd1);
      run_mix(pk4(16'h0800, 0, 0, 0), 32'h0000_0010, -1, 1'b0, "t5c");
      check("t5c_lit", 32'(MIXED), 32'h0800);
      finish_idle("t5c");

      // Reset during MAC
      run_mix(pk4(16'h9000, 16'h9000, 0, 0), 32'h0000_1010, -1, 1'b0, "t6pre");
      finish_idle("t6pre");
      CH_IN = pk4(16'h1000, 0, 0, 0);
      GAIN  = 32'h0000_0010;
      CEN   = 1'b1;
      @(negedge CLK96);
      CEN = 1'b0;
      @(negedge CLK96);
      RESET96_N = 1'b0;
      #1;
      check("t6_mixed", 32'(MIXED), 32'd0);
      check("t6_busy", 32'(BUSY), 32'd0);
      check("t6_peak", 32'(PEAK), 32'd0);
      check("t6_ovr", 32'(OVERRUN), 32'd0);
      check("t6_samp", 32'(SAMPLE), 32'd0);
      m_att  = 0;
      m_peak = 1'b0;
      m_ovr  = 1'b0;
      @(negedge CLK96);
      RESET96_N = 1'b1;
      count_samples(12, "t6_no_sample");
      run_mix(pk4(16'h1000, 0, 0, 0), 32'h0000_0010, -1, 1'b0, "t6post");
      check("t6post_lit", 32'(MIXED), 32'h1000);
      finish_idle("t6post");

      // Random mixes with occasional mute toggles and flag clears
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(3) == 0) MUTE = ~MUTE;
         if ($urandom_range(4) == 0) clear_flags();
         run_mix(rnd64(), 32'($urandom), -1, 1'b0, "rnd");
         finish_idle("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
